// File: rtl/fp32_div.sv
// Iterative IEEE-754 single-precision divider: one quotient bit per cycle by
// restoring division, round-to-nearest-even, denormals flushed to zero.
module fp32_div #(
  parameter logic [31:0] NAN_VALUE = 32'h7FC0_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        ready_out,
  output logic        valid_out,
  output logic [31:0] c_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    ROUND  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic        [4:0]  iter;
  logic               accept;

  logic        [7:0]  ea;
  logic        [7:0]  eb;
  logic               za;
  logic               zb;
  logic               ia;
  logic               ib;
  logic signed [9:0]  exp_in;

  logic               sign_p0;
  logic        [23:0] fb_p0;
  logic        [24:0] rem_p0;
  logic        [26:0] q_p0;
  logic signed [9:0]  exp_p0;
  logic               nan_p0;
  logic               inf_p0;
  logic               zero_p0;
  logic               ge;
  logic        [23:0] rem_sub;

  logic        [23:0] mant_p1;
  logic               guard_p1;
  logic               sticky_p1;
  logic signed [9:0]  exp_p1;

  logic        [23:0] rnd;
  logic signed [9:0]  exp_rnd;
  logic        [31:0] result;

  logic        [31:0] res_p2;
  logic               vld_p2;

  // Returns {carry, fraction}; carry means the significand rolled over to 2^24.
  function automatic logic [23:0] round_rne(input logic [23:0] mant,
                                            input logic guard,
                                            input logic sticky);
    logic inc;
    inc = guard & (sticky | mant[0]);
    return {inc & (&mant), mant[22:0] + {22'd0, inc}};
  endfunction

  function automatic logic [31:0] pack_result(input logic              sign,
                                              input logic signed [9:0] exp,
                                              input logic [22:0]       frac,
                                              input logic              nan,
                                              input logic              inf,
                                              input logic              zero);
    if (nan)                 return NAN_VALUE;
    else if (inf)            return {sign, 8'hFF, 23'd0};
    else if (zero)           return {sign, 31'd0};
    else if (exp >= 10'sd255) return {sign, 8'hFF, 23'd0};
    else if (exp <= 10'sd0)  return {sign, 31'd0};
    else                     return {sign, exp[7:0], frac};
  endfunction

  assign ea     = a_in[30:23];
  assign eb     = b_in[30:23];
  assign za     = (ea == 8'h00);
  assign zb     = (eb == 8'h00);
  assign ia     = (ea == 8'hFF);
  assign ib     = (eb == 8'hFF);
  assign exp_in = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      iter  <= 5'd0;
    end else begin
      state <= state_nxt;
      if (state == DIVIDE) iter <= iter + 5'd1;
      else                 iter <= 5'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_in) state_nxt = DIVIDE;
      DIVIDE:  if (iter == 5'd26) state_nxt = NORM;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_out = (state == IDLE);
  end

  assign accept = valid_in && ready_out && !rst_in;

  // Stage p0: operand capture and the 27 restoring-division iterations.
  // While rem >= fb the difference is below fb < 2^24, so 24 bits suffice.
  assign ge      = (rem_p0 >= {1'b0, fb_p0});
  assign rem_sub = rem_p0[23:0] - fb_p0;

  always_ff @(posedge clk_in) begin
    if (accept) begin
      sign_p0 <= a_in[31] ^ b_in[31];
      fb_p0   <= {~zb, b_in[22:0]};
      rem_p0  <= {1'b0, ~za, a_in[22:0]};
      q_p0    <= 27'd0;
      exp_p0  <= exp_in;
      nan_p0  <= (za && zb) || (ia && ib);
      inf_p0  <= ia || zb;
      zero_p0 <= za || ib;
    end else if (state == DIVIDE) begin
      rem_p0 <= ge ? {rem_sub, 1'b0} : {rem_p0[23:0], 1'b0};
      q_p0   <= {q_p0[25:0], ge};
    end

    // Stage p1: normalise so the significand has its leading one at bit 23.
    if (state == NORM) begin
      if (q_p0[26]) begin
        mant_p1   <= q_p0[26:3];
        guard_p1  <= q_p0[2];
        sticky_p1 <= (|q_p0[1:0]) | (|rem_p0);
        exp_p1    <= exp_p0;
      end else begin
        mant_p1   <= q_p0[25:2];
        guard_p1  <= q_p0[1];
        sticky_p1 <= q_p0[0] | (|rem_p0);
        exp_p1    <= exp_p0 - 10'sd1;
      end
    end

    // Stage p2: rounded and special-case-resolved result.
    if (state == ROUND) res_p2 <= result;
  end

  always_comb begin
    rnd     = round_rne(mant_p1, guard_p1, sticky_p1);
    exp_rnd = exp_p1 + $signed({9'd0, rnd[23]});
    result  = pack_result(sign_p0, exp_rnd, rnd[22:0], nan_p0, inf_p0, zero_p0);
  end

  // Output register: one edge after ROUND, overlapping the next accept.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_p2    <= 1'b0;
      valid_out <= 1'b0;
      c_out     <= 32'd0;
    end else begin
      vld_p2    <= (state == ROUND);
      valid_out <= vld_p2;
      if (vld_p2) c_out <= res_p2;
    end
  end

endmodule

// File: tb/tb_fp32_div.sv
// Directed bench for fp32_div: exact-quotient reference model with a per-cycle
// scoreboard, plus literal expectations on results and latency.
module tb_fp32_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] a_in = 32'd0;
  logic [31:0] b_in = 32'd0;
  logic        ready_out;
  logic        valid_out;
  logic [31:0] c_out;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  typedef struct {
    int          due;
    logic [31:0] val;
  } exp_t;

  exp_t        out_q[$];
  bit          ready_m   = 1'b1;
  bit          exp_valid = 1'b0;
  bit          chk_en    = 1'b0;
  logic [31:0] cur_c     = 32'd0;
  int          free_at   = 0;

  always #5 clk = ~clk;

  fp32_div dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .valid_in (valid_in),
    .a_in     (a_in),
    .b_in     (b_in),
    .ready_out(ready_out),
    .valid_out(valid_out),
    .c_out    (c_out)
  );

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic checkint(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Exact quotient of the significands, then round-to-nearest-even on 24 bits.
  function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b);
    logic        sign;
    int          ea, eb, e, sh;
    bit          za, zb, ia, ib;
    logic [63:0] fa, fb, num, qt, rm, keep, lost, half;
    sign = a[31] ^ b[31];
    ea = a[30:23];
    eb = b[30:23];
    za = (ea == 0);  zb = (eb == 0);
    ia = (ea == 255); ib = (eb == 255);
    if ((za && zb) || (ia && ib)) return 32'h7FC0_0000;
    if (ia || zb) return {sign, 8'hFF, 23'd0};
    if (za || ib) return {sign, 31'd0};
    fa = {40'd0, 1'b1, a[22:0]};
    fb = {40'd0, 1'b1, b[22:0]};
    e = ea - eb + 127;
    num = fa << 26;
    qt = num / fb;
    rm = num % fb;
    if (qt >= (64'd1 << 26)) sh = 3;
    else begin
      sh = 2;
      e = e - 1;
    end
    keep = qt >> sh;
    lost = qt & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (lost > half || (lost == half && (rm != 0 || keep[0]))) keep = keep + 64'd1;
    if (keep == (64'd1 << 24)) begin
      keep = 64'd1 << 23;
      e = e + 1;
    end
    if (e >= 255) return {sign, 8'hFF, 23'd0};
    if (e <= 0) return {sign, 31'd0};
    return {sign, e[7:0], keep[22:0]};
  endfunction

  // Reference timing: result due 30 edges after accept; idle again 29 edges after.
  initial forever begin
    exp_t ent;
    @(posedge clk);
    edge_n++;
    exp_valid = 1'b0;
    if (rst) begin
      out_q.delete();
      ready_m = 1'b1;
      cur_c = 32'd0;
    end else begin
      if (out_q.size() > 0 && out_q[0].due == edge_n) begin
        exp_valid = 1'b1;
        cur_c = out_q[0].val;
        void'(out_q.pop_front());
      end
      if (ready_m && valid_in) begin
        ent.due = edge_n + 30;
        ent.val = model_div(a_in, b_in);
        out_q.push_back(ent);
        ready_m = 1'b0;
        free_at = edge_n + 29;
      end else if (!ready_m && edge_n == free_at) begin
        ready_m = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check1("sb_valid_out", valid_out, exp_valid);
      check1("sb_ready_out", ready_out, ready_m);
      check32("sb_c_out", c_out, cur_c);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_ready();
    for (int i = 0; i < 40 && !ready_out; i++) @(negedge clk);
  endtask

  task automatic wait_valid(output bit seen, output int at);
    seen = 1'b0;
    at = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (valid_out) begin
        seen = 1'b1;
        at = edge_n;
      end
    end
  endtask

  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int e0, e1;
    bit seen;
    wait_ready();
    a_in = a;
    b_in = b;
    valid_in = 1'b1;
    @(negedge clk);
    e0 = edge_n;
    valid_in = 1'b0;
    wait_valid(seen, e1);
    check1({nm, "_seen"}, seen, 1'b1);
    if (seen) begin
      checkint({nm, "_latency"}, e1 - e0, 30);
      check32({nm, "_c"}, c_out, exp);
    end
  endtask

  initial begin
    int e0, e1, e2, pulses;
    bit seen;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check1("reset_ready", ready_out, 1'b1);
    check1("reset_valid", valid_out, 1'b0);
    check32("reset_c", c_out, 32'd0);

    check32("model_6_2", model_div(32'h40C0_0000, 32'h4000_0000), 32'h4040_0000);
    check32("model_1_3", model_div(32'h3F80_0000, 32'h4040_0000), 32'h3EAA_AAAB);
    check32("model_ovf", model_div(32'h7F00_0000, 32'h3E80_0000), 32'h7F80_0000);

    run_op("div_6_2",      32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
    run_op("div_1_3",      32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB);
    run_op("div_1_1",      32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    run_op("div_2_3",      32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAB);
    run_op("div_m5_2",     32'hC0A0_0000, 32'h4000_0000, 32'hC020_0000);
    run_op("neg_by_zero",  32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000);
    run_op("zero_by_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000);
    run_op("inf_by_inf",   32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000);
    run_op("one_by_ninf",  32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000);
    run_op("nan_as_inf",   32'h7FC0_0000, 32'h3F80_0000, 32'h7F80_0000);
    run_op("overflow",     32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000);
    run_op("underflow",    32'h0080_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("denormal_a",   32'h0000_0001, 32'h3F80_0000, 32'h0000_0000);

    // Back-to-back issue with valid_in held high.
    wait_ready();
    a_in = 32'h40C0_0000;
    b_in = 32'h4000_0000;
    valid_in = 1'b1;
    @(negedge clk);
    e0 = edge_n;
    a_in = 32'h3F80_0000;
    b_in = 32'h4040_0000;
    wait_valid(seen, e1);
    check1("b2b_first_seen", seen, 1'b1);
    checkint("b2b_first_latency", e1 - e0, 30);
    check32("b2b_first_c", c_out, 32'h4040_0000);
    check1("b2b_second_accepted", ready_out, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid_in = i[0];
      a_in = 32'h3F80_0000;
      b_in = 32'h3F80_0000;
    end
    valid_in = 1'b0;
    wait_valid(seen, e2);
    check1("b2b_second_seen", seen, 1'b1);
    checkint("b2b_spacing", e2 - e1, 30);
    check32("b2b_second_c", c_out, 32'h3EAA_AAAB);
    pulses = 0;
    repeat (35) begin
      @(negedge clk);
      if (valid_out) pulses++;
    end
    checkint("b2b_no_extra_results", pulses, 0);

    // Reset at edge 10 of an operation.
    wait_ready();
    a_in = 32'h40C0_0000;
    b_in = 32'h4000_0000;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_out) pulses++;
    end
    checkint("abort_no_pulse", pulses, 0);
    check32("abort_c_cleared", c_out, 32'd0);
    check1("abort_ready", ready_out, 1'b1);
    run_op("after_abort", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp32_div.md
Name: fp32_div

Overview:
- Iterative IEEE-754 single-precision divider, c = a / b; the inverse companion of the pipelined fp32 multiplier in the same vertex/shading datapath.
- Radix-2 restoring division, one quotient bit per cycle.
- Single operation in flight, fixed latency, valid/ready input handshake, one-cycle valid_out result pulse.
- Same number conventions as the multiplier: exponent 0 = zero (denormals flushed), exponent 255 = infinity/NaN class.

Parameters:
NAN_VALUE, 32'h7FC0_0000, pattern output for invalid operations (0/0, inf/inf).

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
valid_in  input  1  operands valid; accepted on an edge where valid_in && ready_out
a_in  input  32  dividend, IEEE-754 fp32
b_in  input  32  divisor, IEEE-754 fp32
ready_out  output  1  high only in IDLE; able to accept an operation
valid_out  output  1  one-cycle pulse; c_out valid
c_out  output  32  quotient, IEEE-754 fp32; held until the next result

Behaviour:
- Reset, synchronous on rst_in: state=IDLE, ready_out=1, valid_out=0, c_out=0. Reset mid-operation aborts it silently: no valid_out pulse. Inputs are ignored while rst_in=1.
- States: IDLE -> DIVIDE -> NORM -> ROUND -> IDLE.
- Accept (edge 0, IDLE with valid_in=1):
  - latch sign=a[31]^b[31];
  - latch fa={|a[30:23], a[22:0]}, fb likewise;
  - latch e = ea - eb + 127 (10-bit signed);
  - latch special-case flags;
  - rem=fa, q=0; ready_out falls; go to DIVIDE.
- DIVIDE, edges 1..27, one iteration per edge:
  - if rem >= fb: rem = (rem - fb) << 1, shift in 1;
  - else: rem <<= 1, shift in 0.
  - Use a 25-bit rem. The result is a 27-bit q, with q[26] as the integer bit.
- NORM, edge 28:
  - if q[26]=1: mant=q[26:3], guard=q[2], sticky=|q[1:0] | (rem!=0);
  - else: mant=q[25:2], guard=q[1], sticky=q[0] | (rem!=0), and e = e-1.
- ROUND, edge 29:
  - round to nearest even: increment if guard && (sticky || mant[0]);
  - if mant overflows to 2^24: mant=2^23, e = e+1.
- Output, edge 30: c_out registered, valid_out=1 for exactly one cycle, state=IDLE, ready_out=1.
  - A new operation may be accepted at edge 30 itself (valid_in && ready_out during the valid_out cycle) → back-to-back issue every 30 cycles.
- Fixed latency: valid_out is high during the cycle after edge 30, i.e. 30 clock edges after the accepting edge. This holds for all inputs, including special cases, which still traverse every state.
- Result selection at edge 29, priority order:
  1. a zero && b zero, or a inf && b inf → NAN_VALUE.
  2. a inf or b zero → {sign, 8'hFF, 23'b0}.
  3. a zero or b inf → {sign, 31'b0}.
  4. final e >= 255 → {sign, 8'hFF, 23'b0} (overflow).
  5. final e <= 0 → {sign, 31'b0} (flush underflow).
  6. otherwise {sign, e[7:0], mant[22:0]}.
- Input NaN fraction bits are not propagated: a NaN input is treated as infinity.
- valid_in while ready_out=0 is ignored; there is no queueing and no backpressure on the output.

Test Plan:
1. Basic and latency: a=0x40C00000 (6.0), b=0x40000000 (2.0) → c_out=0x40400000; valid_out high exactly 30 edges after accept, for one cycle only; ready_out low edges 1..29.
2. Rounding: a=0x3F800000, b=0x40400000 (1/3) → 0x3EAAAAAB. a=0x3F800000, b=0x3F800000 → 0x3F800000 (q[26]=1 path).
3. Specials:
   - 0xBF800000 / 0x00000000 → 0xFF800000;
   - 0x00000000 / 0x00000000 → 0x7FC00000;
   - 0x7F800000 / 0x7F800000 → 0x7FC00000;
   - 0x3F800000 / 0xFF800000 → 0x80000000;
   - all with 30-edge latency.
4. Range:
   - 0x7F000000 / 0x3E800000 → 0x7F800000 (e=256 overflow);
   - 0x00800000 / 0x40000000 → 0x00000000 (e=0 flush);
   - denormal a=0x00000001 / 0x3F800000 → 0x00000000.
5. Handshake: hold valid_in=1 with ops (6/2) then (1/3):
   - second accepted on the edge where the first valid_out is seen;
   - results 0x40400000 then 0x3EAAAAAB, 30 edges apart;
   - valid_in pulses while busy produce no extra results.
6. Reset mid-op: assert rst_in for one cycle at edge 10 of an operation → valid_out never pulses, c_out=0, ready_out=1 after reset; the next op (6/2) completes normally with 0x40400000.
